// File: rtl/pattern_det_sched.sv
// pattern_det_sched
// -----------------
// Round-robin front end that time-shares one serial pattern detector among
// NREQ requesters. A granted requester's WLEN-bit word is latched, the
// detector is cleared, the word is shifted out MSB first on det_ip (one bit
// per clock), and the detector count is captured and returned with a
// one-cycle done pulse tagged with the requester id.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     asynchronous, active-low reset
//   req       per-requester request level (sampled only in IDLE)
//   req_data  packed words, requester i uses bits [i*WLEN +: WLEN]
//   gnt       one-hot, one-cycle grant pulse
//   busy      high whenever a transaction is in progress
//   det_clr   synchronous clear to the detector, pulsed with the grant
//   det_ip    serial bit to the detector
//   det_cnt   detector count
//   done      one-cycle result-valid pulse
//   done_id   id of the requester whose result is on result
//   result    captured detector count, held until the next done
module pattern_det_sched #(
    parameter int NREQ = 4,
    parameter int WLEN = 8,
    parameter int CW   = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*WLEN-1:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 det_clr,
    output logic                 det_ip,
    input  logic [CW-1:0]        det_cnt,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [CW-1:0]        result
);

    localparam int BW = (WLEN > 1) ? $clog2(WLEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    // First set request at or after ptr, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] f_rr_pick(
        input logic [NREQ-1:0] req_v,
        input logic [IDW-1:0]  ptr
    );
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = {IDW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req_v[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [WLEN-1:0] r_word;
    logic [BW-1:0]   r_bit;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_det_clr;
    logic            r_det_ip;
    logic            r_done;
    logic [IDW-1:0]  r_done_id;
    logic [CW-1:0]   r_result;

    logic            w_any_req;
    logic [IDW-1:0]  w_pick_id;
    logic [WLEN-1:0] w_pick_word;
    logic [IDW-1:0]  w_next_ptr;
    logic [NREQ-1:0] w_gnt_vec;

    assign w_any_req   = |req;
    assign w_pick_id   = f_rr_pick(req, r_ptr);
    assign w_pick_word = req_data[int'(w_pick_id)*WLEN +: WLEN];
    assign w_gnt_vec   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_id;
    // Pointer moves just past the winner so it becomes lowest priority.
    assign w_next_ptr  = (w_pick_id == IDW'(NREQ-1)) ? {IDW{1'b0}}
                                                     : w_pick_id + IDW'(1);

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= {IDW{1'b0}};
            r_id      <= {IDW{1'b0}};
            r_word    <= {WLEN{1'b0}};
            r_bit     <= {BW{1'b0}};
            r_gnt     <= {NREQ{1'b0}};
            r_busy    <= 1'b0;
            r_det_clr <= 1'b0;
            r_det_ip  <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= {IDW{1'b0}};
            r_result  <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_det_ip <= 1'b0;
                    r_done   <= 1'b0;
                    if (w_any_req) begin
                        r_id      <= w_pick_id;
                        r_word    <= w_pick_word;
                        r_ptr     <= w_next_ptr;
                        r_gnt     <= w_gnt_vec;
                        r_det_clr <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_CLR;
                    end else begin
                        r_gnt     <= {NREQ{1'b0}};
                        r_det_clr <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    r_gnt     <= {NREQ{1'b0}};
                    r_det_clr <= 1'b0;
                    r_det_ip  <= r_word[WLEN-1];
                    r_bit     <= BW'(WLEN-1);
                    r_state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // r_bit indexes the bit currently on det_ip; once bit 0
                    // has been presented the line returns low.
                    if (r_bit == {BW{1'b0}}) begin
                        r_det_ip <= 1'b0;
                        r_state  <= ST_SETTLE;
                    end else begin
                        r_det_ip <= r_word[r_bit - BW'(1)];
                        r_bit    <= r_bit - BW'(1);
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SETTLE: begin
                    // Detector took the last bit on the previous edge, so its
                    // count is final here; captured without modification.
                    r_det_ip  <= 1'b0;
                    r_result  <= det_cnt;
                    r_done_id <= r_id;
                    r_done    <= 1'b1;
                    r_state   <= ST_REPORT;
                end
                ST_REPORT: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt     <= {NREQ{1'b0}};
                    r_det_clr <= 1'b0;
                    r_det_ip  <= 1'b0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign det_clr = r_det_clr;
    assign det_ip  = r_det_ip;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign result  = r_result;

endmodule

// File: tb/tb_pattern_det_sched.sv
// Testbench for pattern_det_sched: a detector stub counts ones since det_clr;
// expectations come from a transaction-level model (round-robin pick over a
// request vector, MSB-first bit list of the latched word, popcount result).
module tb_pattern_det_sched;

    localparam int NREQ = 4;
    localparam int WLEN = 8;
    localparam int CW   = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*WLEN-1:0] req_data;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 det_clr;
    logic                 det_ip;
    logic [CW-1:0]        det_cnt;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic [CW-1:0]        result;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;
    logic [CW-1:0] m_last_result = '0;

    pattern_det_sched #(.NREQ(NREQ), .WLEN(WLEN), .CW(CW), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .busy     (busy),
        .det_clr  (det_clr),
        .det_ip   (det_ip),
        .det_cnt  (det_cnt),
        .done     (done),
        .done_id  (done_id),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector stub: count of ones sampled since the last det_clr.
    always @(posedge clk or negedge reset) begin
        if (!reset)       det_cnt <= '0;
        else if (det_clr) det_cnt <= '0;
        else if (det_ip)  det_cnt <= det_cnt + 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the model pointer.
    function automatic int model_pick(input logic [NREQ-1:0] reqv);
        for (int i = 0; i < NREQ; i++) begin
            if (reqv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic wait_gnt(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    // One full transaction; entry is #1 after an edge with the DUT idle.
    task automatic do_txn(input logic [NREQ-1:0] reqv, input logic [NREQ-1:0] next_req,
                          input bit chg, input bit chk_gap);
        int cyc;
        int exp_id;
        logic [WLEN-1:0] w;
        logic [CW-1:0]   exp_res;
        req     = reqv;
        exp_id  = model_pick(reqv);
        w       = req_data[exp_id*WLEN +: WLEN];
        exp_res = CW'($countones(w));
        wait_gnt(cyc);
        check_eq("gnt", gnt, 32'(1) << exp_id);
        if (chk_gap) check_eq("grant_gap", WLEN + 3 + cyc, WLEN + 4);
        check_eq("det_clr_hi", det_clr, 1);
        check_eq("busy_hi", busy, 1);
        m_ptr = (exp_id + 1) % NREQ;
        @(posedge clk); #1;
        check_eq("gnt_pulse", gnt, 0);
        check_eq("det_clr_lo", det_clr, 0);
        check_eq("det_ip_msb", det_ip, w[WLEN-1]);
        req = next_req;
        if (chg) req_data = $urandom;
        for (int k = 2; k <= WLEN; k++) begin
            @(posedge clk); #1;
            check_eq("det_ip", det_ip, w[WLEN-k]);
        end
        @(posedge clk); #1;
        check_eq("det_ip_settle", det_ip, 0);
        check_eq("done_early", done, 0);
        @(posedge clk); #1;
        check_eq("done", done, 1);
        check_eq("done_id", done_id, exp_id);
        check_eq("result", result, exp_res);
        @(posedge clk); #1;
        check_eq("done_pulse", done, 0);
        check_eq("busy_lo", busy, 0);
        check_eq("result_hold", result, exp_res);
        m_last_result = exp_res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = {8'h81, 8'h0F, 8'h00, 8'hFF};
        // Reset held with all requests pending: nothing may move.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_gnt", gnt, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_det_ip", det_ip, 0);
            check_eq("rst_result", result, 0);
        end
        reset = 1'b1;

        // Round robin with all requests held: 0,1,2,3,0.
        do_txn(4'b1111, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_txn(4'b1111, 4'b1111, 1'b0, 1'b1);

        // Pointer wrap: serve 3, then with 0 and 3 pending, 0 wins.
        do_txn(4'b1000, 4'b1001, 1'b0, 1'b1);
        do_txn(4'b1001, 4'b1001, 1'b0, 1'b1);
        do_txn(4'b1001, 4'b0000, 1'b0, 1'b1);

        // Single request, word B6 on requester 2.
        req_data[2*WLEN +: WLEN] = 8'hB6;
        do_txn(4'b0100, 4'b0000, 1'b0, 1'b0);

        // Data change one cycle after grant must not affect the result.
        req_data[1*WLEN +: WLEN] = 8'hE7;
        do_txn(4'b0010, 4'b0000, 1'b1, 1'b0);

        // Reset in the middle of SHIFT.
        req_data = {8'h55, 8'hC3, 8'h3C, 8'hF1};
        req = 4'b0001;
        wait_gnt(cyc);
        check_eq("mid_gnt", gnt, 4'b0001);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_det_ip", det_ip, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_done_id", done_id, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("mid_rst_done", done, 0);
            check_eq("mid_rst_gnt", gnt, 0);
        end
        m_ptr = 0;
        req   = 4'b0010;
        reset = 1'b1;
        do_txn(4'b0010, 4'b0000, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 16; i++) begin
            req_data = $urandom;
            do_txn(NREQ'($urandom_range(1, 15)), NREQ'($urandom_range(0, 15)),
                   bit'($urandom_range(0, 1)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_det_sched.md
Name: pattern_det_sched

Overview:
- Round-robin scheduler that shares one serial pattern-detector/counter (1-bit `ip`, Moore count output) among NREQ requesters.
- Each requester presents a WLEN-bit word. The scheduler grants one requester, clears the detector, and shifts the word in MSB first, one bit per clock.
- It then captures the detector count and returns it with a done pulse tagged by requester id.
- Sits between bit-stream producers and the single detector instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WLEN, 8, bits per word shifted into the detector
- CW, 4, width of detector count / result
- IDW, 2, requester id width; must be ≥ ceil(log2(NREQ))

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level
- req_data  in  NREQ*WLEN  packed words; requester i uses bits [i*WLEN +: WLEN]
- gnt  out  NREQ  one-hot, one-cycle grant pulse
- busy  out  1  high whenever state ≠ IDLE
- det_clr  out  1  active-high synchronous clear to detector
- det_ip  out  1  serial bit to detector
- det_cnt  in  CW  detector count output
- done  out  1  one-cycle result-valid pulse
- done_id  out  IDW  id of requester whose result is on `result`
- result  out  CW  captured count, held until next done

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, round-robin pointer=0.
  - gnt, busy, det_clr, det_ip, done, done_id and result all 0.
  - An in-flight transaction is dropped with no done. Normal operation resumes on the first edge after release.
- All outputs are registered.
- FSM states: IDLE, CLR, SHIFT, SETTLE, REPORT.
- Edge E0, IDLE with |req:
  - Choose the first set req at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's req_data word and id.
  - gnt[id]=1, det_clr=1, busy=1, state→CLR.
  - Pointer ← id+1 (wraps).
  - req=0 in IDLE: stay in IDLE, det_ip=0.
- E1, CLR→SHIFT: gnt=0, det_clr=0, det_ip=word[WLEN-1], bit index=WLEN-1.
- Ek (k=2..WLEN), SHIFT: det_ip=word[WLEN-k].
- E(WLEN+1), SHIFT→SETTLE:
  - det_ip=0.
  - The detector samples the last bit on this edge.
- E(WLEN+2), SETTLE→REPORT: result←det_cnt, done_id←latched id, done=1.
- E(WLEN+3), REPORT→IDLE: done=0, busy=0. result and done_id hold.
- Timing:
  - Service time: WLEN+3 cycles from grant edge to IDLE.
  - Next arbitration edge: E(WLEN+4).
  - With default WLEN=8, done is high between E10 and E11.
- Requester contract:
  - Hold req and req_data stable until gnt.
  - Data is sampled on the grant edge; later changes are ignored.
  - req in any non-IDLE state is ignored, not queued. The requester keeps req high to be considered at the next IDLE.
- Starvation: round robin guarantees service within NREQ transactions.
- Same requester re-requesting after done is granted only after all other pending requesters.
- det_ip=0 in IDLE, CLR, SETTLE and REPORT.
- det_cnt is captured raw: no saturation and no arithmetic.

Test Plan:
- Bench detector stub: CW-bit count of 1s sampled since det_clr.
- Reset in idle:
  - Stimulus: reset=0 with req=4'b1111.
  - Required: gnt=0, busy=0, done=0, det_ip=0, result=0; no grant until after release.
- Single request:
  - Stimulus: req=4'b0100, word2=8'hB6.
  - Required:
    - gnt=4'b0100 for one cycle.
    - det_clr high the same cycle.
    - det_ip sequence 1,0,1,1,0,1,1,0 on E1..E8.
    - done at E10 with done_id=2, result=5.
    - busy low after E11.
- Round robin:
  - Stimulus: req=4'b1111 held; words FF, 00, 0F, 81.
  - Required:
    - Grant order 0,1,2,3,0.
    - Results 8, 0, 4, 2.
    - Successive grants 12 cycles apart.
- Pointer wrap:
  - Stimulus: after serving id 3, req=4'b1001.
  - Required: id 0 granted before id 3.
- Reset mid-SHIFT:
  - Stimulus: reset=0 at E4.
  - Required:
    - Outputs immediately 0 with no done.
    - After release, req=4'b0010 is granted first and yields a correct fresh result.
- Data change after grant:
  - Stimulus: change req_data one cycle after gnt.
  - Required: det_ip stream and result reflect the originally latched word.
